// File: rtl/pipeline_hazard_controller_if.sv
// Purpose: bundles the hazard-detect inputs and stall/flush/bubble controls
//          exchanged between the pipeline datapath and the hazard controller.
// Latency: none (wires only). Backpressure: n/a; the controller's outputs are the stall mechanism.
// Modports: master = pipeline datapath side (drives hazard info, receives controls)
//           slave  = hazard controller side (receives hazard info, drives controls)
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 16
);
  // hazard information from the pipeline registers
  logic [4:0]       IFID_Rs;
  logic [4:0]       IFID_Rt;
  logic             IFID_UsesRt;
  logic             IDEX_MemRead;
  logic [4:0]       IDEX_Rt;
  logic             EXMEM_Branch;
  logic             EXMEM_ALUZero;
  logic             EXMEM_MemReq;
  logic             MemReady;
  // pipeline register controls
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEXWrite;
  logic             EXMEMWrite;
  logic             PCSrc;
  logic             IFIDFlush;
  logic             IDEXBubble;
  logic             EXMEMBubble;
  logic             MEMWBBubble;
  // status / debug
  logic             MemError;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt,
           EXMEM_Branch, EXMEM_ALUZero, EXMEM_MemReq, MemReady,
    input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, PCSrc,
           IFIDFlush, IDEXBubble, EXMEMBubble, MEMWBBubble,
           MemError, StallCycles, FlushCount
  );

  modport slave (
    input  IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt,
           EXMEM_Branch, EXMEM_ALUZero, EXMEM_MemReq, MemReady,
    output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, PCSrc,
           IFIDFlush, IDEXBubble, EXMEMBubble, MEMWBBubble,
           MemError, StallCycles, FlushCount
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Purpose: stall/flush sequencer for the 5-stage MIPS pipeline (load-use, taken branch, memory wait).
// Latency: controls are combinational from inputs and state; state/counters update on the next rising Clk.
// Backpressure: a pending data-memory access freezes every stage until MemReady or the wait timeout.
// Ports: Clk, Rst (async active-low) plain; hz (slave modport) carries hazard info in,
//        write-enables / PCSrc / flush / bubbles / MemError / StallCycles / FlushCount out.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                         Clk,
  input  logic                         Rst,
  pipeline_hazard_controller_if.slave  hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state_q,     state_d;
  logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic              mem_error_q, mem_error_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic taken;
  logic load_use;
  logic expired;
  logic mem_stall;

  logic pc_write, ifid_write, idex_write, exmem_write;
  logic pc_src, ifid_flush, idex_bubble, exmem_bubble, memwb_bubble;

  always_comb begin
    taken    = hz.EXMEM_Branch & hz.EXMEM_ALUZero;
    // $0 is hardwired zero, so a load targeting it never creates a dependency
    load_use = hz.IDEX_MemRead && (hz.IDEX_Rt != 5'd0) &&
               ((hz.IDEX_Rt == hz.IFID_Rs) ||
                (hz.IFID_UsesRt && (hz.IDEX_Rt == hz.IFID_Rt)));
    expired   = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));
    // once the wait has expired the access is treated as complete
    mem_stall = hz.EXMEM_MemReq & ~hz.MemReady & ~expired;

    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    pc_src       = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;

    if (mem_stall) begin
      // full freeze; the stuck MEM instruction must not retire twice
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (taken) begin
      // kill the three wrong-path instructions in IF, ID and EX
      pc_src       = 1'b1;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
    end else if (load_use) begin
      // hold IF/ID one cycle; the load advances to MEM and the hazard clears
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end

    // stay in MEM_WAIT only while still stalling; counter is 0 in RUN so +1 seeds it to 1
    if (mem_stall) begin
      state_d    = MEM_WAIT;
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end else begin
      state_d    = RUN;
      wait_cnt_d = '0;
    end

    mem_error_d = mem_error_q | (expired & ~hz.MemReady);

    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    flush_cnt_d = flush_cnt_q;
    if (taken && !mem_stall && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // all controls are forced inactive for the whole time reset is held
  assign hz.PCWrite     = Rst & pc_write;
  assign hz.IFIDWrite   = Rst & ifid_write;
  assign hz.IDEXWrite   = Rst & idex_write;
  assign hz.EXMEMWrite  = Rst & exmem_write;
  assign hz.PCSrc       = Rst & pc_src;
  assign hz.IFIDFlush   = Rst & ifid_flush;
  assign hz.IDEXBubble  = Rst & idex_bubble;
  assign hz.EXMEMBubble = Rst & exmem_bubble;
  assign hz.MEMWBBubble = Rst & memwb_bubble;

  assign hz.MemError    = mem_error_q;
  assign hz.StallCycles = stall_cnt_q;
  assign hz.FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  localparam int TO    = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  // control vector order: PCWrite IFIDWrite IDEXWrite EXMEMWrite PCSrc IFIDFlush IDEXBubble EXMEMBubble MEMWBBubble
  localparam logic [8:0] C_NORM  = 9'b1111_0000_0;
  localparam logic [8:0] C_LU    = 9'b0011_0010_0;
  localparam logic [8:0] C_TAKEN = 9'b1111_1111_0;
  localparam logic [8:0] C_MEM   = 9'b0000_0000_1;
  localparam logic [8:0] C_ZERO  = 9'b0000_0000_0;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       mr;
    logic [4:0] irt;
    logic       br;
    logic       z;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct {
    in_t        i;
    logic [8:0] exp;
  } vec_t;

  logic Clk;
  logic Rst;

  pipeline_hazard_controller_if #(.CNT_W(CW)) bus ();

  pipeline_hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .hz  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec;
  int n_err;

  // reference model state: memory-wait bookkeeping and the three status values
  bit m_waiting;
  int m_wait_cycles;
  bit m_err;
  int m_stalls;
  int m_flushes;

  function automatic in_t mk(int rs, int rt, int ur, int mr, int irt,
                             int br, int z, int req, int rdy);
    in_t t;
    t.rs  = 5'(rs);  t.rt = 5'(rt);  t.ur = 1'(ur);  t.mr = 1'(mr);
    t.irt = 5'(irt); t.br = 1'(br);  t.z  = 1'(z);
    t.req = 1'(req); t.rdy = 1'(rdy);
    return t;
  endfunction

  function automatic logic [8:0] dut_ctl();
    return {bus.PCWrite, bus.IFIDWrite, bus.IDEXWrite, bus.EXMEMWrite, bus.PCSrc,
            bus.IFIDFlush, bus.IDEXBubble, bus.EXMEMBubble, bus.MEMWBBubble};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_ctl(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: controls got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t t);
    bus.IFID_Rs       = t.rs;
    bus.IFID_Rt       = t.rt;
    bus.IFID_UsesRt   = t.ur;
    bus.IDEX_MemRead  = t.mr;
    bus.IDEX_Rt       = t.irt;
    bus.EXMEM_Branch  = t.br;
    bus.EXMEM_ALUZero = t.z;
    bus.EXMEM_MemReq  = t.req;
    bus.MemReady      = t.rdy;
  endtask

  task automatic model_reset();
    m_waiting = 0; m_wait_cycles = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
  endtask

  // Applies one cycle of stimulus: called at a negedge, returns at the next negedge.
  // Checks the controls against the model (and a table value when given) and the
  // status outputs against what the model accumulated so far, then advances the model.
  task automatic run_cycle(input in_t t, input bit use_tbl, input logic [8:0] tbl_exp,
                           input string nm);
    bit taken, lu, timed_out, frozen;
    logic [8:0] exp;
    drive(t);
    #1;
    taken     = t.br && t.z;
    lu        = t.mr && (t.irt != 0) && ((t.irt == t.rs) || (t.ur && (t.irt == t.rt)));
    timed_out = m_waiting && (m_wait_cycles >= TO);
    frozen    = t.req && !t.rdy && !timed_out;
    if (frozen)      exp = C_MEM;
    else if (taken)  exp = C_TAKEN;
    else if (lu)     exp = C_LU;
    else             exp = C_NORM;

    chk_ctl({nm, " model"}, dut_ctl(), exp);
    if (use_tbl) chk_ctl({nm, " table"}, dut_ctl(), tbl_exp);
    chk({nm, " StallCycles"}, int'(bus.StallCycles), m_stalls);
    chk({nm, " FlushCount"},  int'(bus.FlushCount),  m_flushes);
    chk({nm, " MemError"},    int'(bus.MemError),    int'(m_err));

    if (timed_out && !t.rdy) m_err = 1;
    if (frozen) begin
      m_waiting = 1;
      m_wait_cycles++;
    end else begin
      m_waiting = 0;
      m_wait_cycles = 0;
    end
    if (!exp[8]) m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
    if (exp == C_TAKEN) m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
    @(negedge Clk);
  endtask

  task automatic do_reset();
    drive(mk(0,0,0,0,0,0,0,0,0));
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    model_reset();
  endtask

  vec_t tbl[12];
  in_t  idle, memw, lu8;

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    idle = mk(0,0,0,0,0,0,0,0,0);
    memw = mk(0,0,0,0,0,0,0,1,0);
    lu8  = mk(8,0,0,1,8,0,0,0,0);

    tbl[0]  = '{mk(0,0,0,0,0,0,0,0,0), C_NORM};   // idle
    tbl[1]  = '{mk(8,0,0,1,8,0,0,0,0), C_LU};     // load-use on rs
    tbl[2]  = '{mk(0,0,0,1,0,0,0,0,0), C_NORM};   // $0 never stalls
    tbl[3]  = '{mk(3,9,0,1,9,0,0,0,0), C_NORM};   // rt match but rt unused
    tbl[4]  = '{mk(3,9,1,1,9,0,0,0,0), C_LU};     // rt match and used
    tbl[5]  = '{mk(8,0,0,1,8,1,1,0,0), C_TAKEN};  // taken beats load-use
    tbl[6]  = '{mk(0,0,0,0,0,1,0,0,0), C_NORM};   // branch, ALUZero=0
    tbl[7]  = '{mk(0,0,0,0,0,0,1,0,0), C_NORM};   // ALUZero without branch
    tbl[8]  = '{mk(0,0,0,0,0,0,0,1,1), C_NORM};   // access completes at once
    tbl[9]  = '{mk(0,0,0,0,0,1,1,1,0), C_MEM};    // mem stall beats taken
    tbl[10] = '{mk(8,0,0,1,8,0,0,1,1), C_LU};     // release cycle uses lower rules
    tbl[11] = '{mk(0,0,0,0,0,0,0,0,0), C_NORM};

    Rst = 1'b0;
    drive(idle);
    #2;
    chk_ctl("reset controls", dut_ctl(), C_ZERO);
    chk("reset StallCycles", int'(bus.StallCycles), 0);
    chk("reset FlushCount",  int'(bus.FlushCount), 0);
    chk("reset MemError",    int'(bus.MemError), 0);
    @(negedge Clk);
    Rst = 1'b1;
    model_reset();

    // directed table
    for (int k = 0; k < 12; k++) run_cycle(tbl[k].i, 1'b1, tbl[k].exp, $sformatf("tbl%0d", k));
    chk("tbl StallCycles", int'(bus.StallCycles), 4);
    chk("tbl FlushCount",  int'(bus.FlushCount), 1);

    // memory wait: three frozen cycles, release when MemReady rises
    do_reset();
    for (int k = 0; k < 3; k++) run_cycle(memw, 1'b1, C_MEM, "memwait freeze");
    run_cycle(mk(0,0,0,0,0,0,0,1,1), 1'b1, C_NORM, "memwait release");
    chk("memwait StallCycles", int'(bus.StallCycles), 3);
    chk("memwait MemError",    int'(bus.MemError), 0);

    // timeout: MemReady never rises
    do_reset();
    for (int k = 0; k < TO; k++) run_cycle(memw, 1'b1, C_MEM, "timeout freeze");
    run_cycle(memw, 1'b1, C_NORM, "timeout release");
    chk("timeout MemError set", int'(bus.MemError), 1);
    for (int k = 0; k < 3; k++) run_cycle(idle, 1'b1, C_NORM, "after timeout");
    chk("timeout MemError sticky", int'(bus.MemError), 1);
    chk("timeout StallCycles", int'(bus.StallCycles), TO);

    // asynchronous reset in the middle of a memory wait
    do_reset();
    for (int k = 0; k < 3; k++) run_cycle(memw, 1'b1, C_MEM, "prereset freeze");
    #2;
    Rst = 1'b0;
    #1;
    chk_ctl("midwait reset controls", dut_ctl(), C_ZERO);
    chk("midwait reset StallCycles", int'(bus.StallCycles), 0);
    chk("midwait reset MemError", int'(bus.MemError), 0);
    @(negedge Clk);
    Rst = 1'b1;
    model_reset();
    run_cycle(idle, 1'b1, C_NORM, "post reset");
    run_cycle(memw, 1'b1, C_MEM, "post reset fresh wait");
    run_cycle(mk(0,0,0,0,0,0,0,1,1), 1'b1, C_NORM, "post reset release");

    // saturation of the stall counter
    do_reset();
    for (int k = 0; k < 20; k++) run_cycle(lu8, 1'b1, C_LU, "sat loaduse");
    chk("sat StallCycles", int'(bus.StallCycles), CMAX);

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      in_t r;
      r.rs  = 5'($urandom_range(0, 3));
      r.rt  = 5'($urandom_range(0, 3));
      r.ur  = 1'($urandom_range(0, 1));
      r.mr  = 1'($urandom_range(0, 1));
      r.irt = 5'($urandom_range(0, 3));
      r.br  = 1'($urandom_range(0, 3) == 0);
      r.z   = 1'($urandom_range(0, 1));
      r.req = 1'($urandom_range(0, 2) == 0);
      r.rdy = 1'($urandom_range(0, 3) == 0);
      run_cycle(r, 1'b0, C_ZERO, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
